// File: rtl/keypad_pkg.sv
// keypad_pkg: definitions shared by keypad_entry and password_check.
//   PW_WIDTH_DEF  binary password width shared with password_check
//   KEY_*         special key codes from the keypad scanner
//   state_e       keypad_entry FSM states
//   is_digit()    true for key codes 0-9
package keypad_pkg;

  localparam int PW_WIDTH_DEF = 17;

  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hC;

  typedef enum logic [1:0] {
    S_PRI   = 2'd0,  // collecting the first (or only) value
    S_NEW   = 2'd1,  // collecting the new password after a master key
    S_CONV  = 2'd2,  // BCD -> binary conversion running
    S_ISSUE = 2'd3   // one-cycle hand-off to password_check
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD to binary converter, one digit per cycle.
//   clk, rst_n  clock, synchronous active-low reset
//   start_i     load bcd_i and begin; ignored while a conversion runs
//   bcd_i       NUM_DIGITS packed BCD digits, most significant digit in the top nibble
//   done_o      high in the final step cycle; bin_o holds the finished value then
//   bin_o       running accumulator including the current step (acc*10 + digit)
// A conversion always takes exactly NUM_DIGITS cycles; leading zero digits cost
// nothing in correctness, they just contribute 0 to the accumulator.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 5,
  parameter int PW_WIDTH   = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [NUM_DIGITS*4-1:0] bcd_i,
  output logic                    done_o,
  output logic [PW_WIDTH-1:0]     bin_o
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int SW = $clog2(NUM_DIGITS + 1);

  logic [BW-1:0]       sh_q;
  logic [PW_WIDTH-1:0] acc_q;
  logic [SW-1:0]       step_q;
  logic                run_q;
  logic [3:0]          dig;
  logic [PW_WIDTH-1:0] mac;

  assign dig = sh_q[BW-1 -: 4];
  // x10 as x8 + x2 so no multiplier is inferred
  assign mac    = (acc_q << 3) + (acc_q << 1) + PW_WIDTH'(dig);
  assign done_o = run_q && (step_q == SW'(NUM_DIGITS - 1));
  assign bin_o  = mac;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (run_q) begin
      sh_q   <= sh_q << 4;
      acc_q  <= mac;
      step_q <= step_q + SW'(1);
      if (done_o) run_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= bcd_i;
      acc_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: collects keypad digits, converts them to binary and hands the
// value(s) to password_check.
//   clk, rst_n       clock, synchronous active-low reset
//   key_valid        one-cycle key strobe, key_code valid with it
//   key_code         0-9 digit, KEY_CLEAR, KEY_BACKSPACE, KEY_ENTER; others ignored
//   mode_change      sampled on the ENTER that ends the first value; 1 = change request
//   in_password      first value (master key in change mode)
//   change_password  second value, 0 for a plain unlock
//   e_button         one-cycle strobe: outputs valid
//   rs_button        1 = change request, held until the next issue
//   busy             converting/issuing, keys dropped
//   digit_count      digits in the current buffer
//   entry_error      one-cycle pulse on a rejected key (registered, cycle after the key)
// Build option: define ENTRY_TIMEOUT_EN to discard idle partial entries after
// TIMEOUT_CYCLES cycles (treated as CLEAR plus an error pulse).
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int PW_WIDTH   = PW_WIDTH_DEF
`ifdef ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                mode_change,
  output logic [PW_WIDTH-1:0] in_password,
  output logic [PW_WIDTH-1:0] change_password,
  output logic                e_button,
  output logic                rs_button,
  output logic                busy,
  output logic [2:0]          digit_count,
  output logic                entry_error
);

  localparam int BW = NUM_DIGITS * 4;

  state_e              state_q, state_d;
  logic [BW-1:0]       dbuf_q, dbuf_d;     // newest digit in the low nibble
  logic [2:0]          cnt_q, cnt_d;
  logic                second_q, second_d; // conversion in flight is the second value
  logic                mode_q, mode_d;
  logic [PW_WIDTH-1:0] inpw_q, inpw_d;
  logic [PW_WIDTH-1:0] chpw_q, chpw_d;
  logic                rs_q, rs_d;
  logic                err_q, err_d;

  logic                key_ok;
  logic                conv_start;
  logic                conv_done;
  logic [PW_WIDTH-1:0] conv_bin;

  assign busy   = (state_q == S_CONV) || (state_q == S_ISSUE);
  assign key_ok = key_valid && !busy;

  bcd_to_bin_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .PW_WIDTH  (PW_WIDTH)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(conv_start),
    .bcd_i  (dbuf_q),
    .done_o (conv_done),
    .bin_o  (conv_bin)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          armed;
  logic          timeout_hit;

  // A second-value entry times out even with an empty buffer, so an abandoned
  // change request does not leave the master key latched forever.
  assign armed       = (state_q == S_NEW) || ((state_q == S_PRI) && (cnt_q != 3'd0));
  assign timeout_hit = armed && !key_ok && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q + TW'(1);
    if (!armed || key_ok || timeout_hit) idle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    dbuf_d     = dbuf_q;
    cnt_d      = cnt_q;
    second_d   = second_q;
    mode_d     = mode_q;
    inpw_d     = inpw_q;
    chpw_d     = chpw_q;
    rs_d       = rs_q;
    err_d      = 1'b0;
    conv_start = 1'b0;

    case (state_q)
      S_PRI, S_NEW: begin
        if (key_ok) begin
          if (is_digit(key_code)) begin
            if (cnt_q < 3'(NUM_DIGITS)) begin
              dbuf_d = (dbuf_q << 4) | BW'(key_code);
              cnt_d  = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_BACKSPACE) begin
            if (cnt_q == 3'd0) begin
              err_d = 1'b1;
            end else begin
              dbuf_d = dbuf_q >> 4;
              cnt_d  = cnt_q - 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            dbuf_d   = '0;
            cnt_d    = 3'd0;
            second_d = 1'b0;
            state_d  = S_PRI;
          end else if (key_code == KEY_ENTER) begin
            if (cnt_q == 3'd0) begin
              err_d = 1'b1;
            end else begin
              conv_start = 1'b1;
              second_d   = (state_q == S_NEW);
              if (state_q == S_PRI) mode_d = mode_change;
              state_d    = S_CONV;
            end
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        if (timeout_hit) begin
          dbuf_d   = '0;
          cnt_d    = 3'd0;
          second_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_PRI;
        end
`endif
      end

      S_CONV: begin
        if (conv_done) begin
          dbuf_d = '0;
          cnt_d  = 3'd0;
          if (!second_q) begin
            inpw_d = conv_bin;
            if (mode_q) begin
              state_d = S_NEW;
            end else begin
              chpw_d  = '0;
              rs_d    = 1'b0;
              state_d = S_ISSUE;
            end
          end else begin
            chpw_d  = conv_bin;
            rs_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        dbuf_d   = '0;
        cnt_d    = 3'd0;
        second_d = 1'b0;
        state_d  = S_PRI;
      end

      default: state_d = S_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_PRI;
      dbuf_q   <= '0;
      cnt_q    <= 3'd0;
      second_q <= 1'b0;
      mode_q   <= 1'b0;
      inpw_q   <= '0;
      chpw_q   <= '0;
      rs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dbuf_q   <= dbuf_d;
      cnt_q    <= cnt_d;
      second_q <= second_d;
      mode_q   <= mode_d;
      inpw_q   <= inpw_d;
      chpw_q   <= chpw_d;
      rs_q     <= rs_d;
      err_q    <= err_d;
    end
  end

  assign e_button        = (state_q == S_ISSUE);
  assign in_password     = inpw_q;
  assign change_password = chpw_q;
  assign rs_button       = rs_q;
  assign digit_count     = cnt_q;
  assign entry_error     = err_q;

endmodule
